// File: rtl/row_readout_scheduler_pkg.sv
// Shared types and sizing for the row readout scheduler: state encoding,
// row descriptor layout and the batch-count clamp.
package readout_pkg;

  localparam int BATCH_SIZE  = 16;
  localparam int MAX_WIDTH   = 1920;
  localparam int MAX_HEIGHT  = 1080;
  localparam int MAX_BATCHES = MAX_WIDTH / BATCH_SIZE;
  localparam int ADDR_W      = $clog2(MAX_BATCHES);
  localparam int COUNT_W     = ADDR_W + 1;
  localparam int ROW_W       = $clog2(MAX_HEIGHT);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  typedef struct packed {
    logic               half;
    logic [ROW_W-1:0]   row;
    logic [COUNT_W-1:0] count;
  } row_desc_t;

  // Rows wider than the buffer cannot be read past its last word.
  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] cnt);
    logic [COUNT_W-1:0] lim;
    lim = COUNT_W'(MAX_BATCHES);
    if (cnt > lim) begin
      return lim;
    end else begin
      return cnt;
    end
  endfunction

endpackage

// File: rtl/row_readout_scheduler.sv
// Turns completed line-buffer rows into per-batch read commands over a
// valid/ready handshake, with one active and one pending row descriptor.
module row_readout_scheduler
  import readout_pkg::*;
(
  input  logic               I_clk,
  input  logic               I_rst,
  input  logic               I_frame_start,
  input  logic               I_row_done,
  input  logic               I_row_half,
  input  logic [ROW_W-1:0]   I_row_index,
  input  logic [COUNT_W-1:0] I_batch_count,
  output logic               O_cmd_valid,
  input  logic               I_cmd_ready,
  output logic [ADDR_W-1:0]  O_cmd_addr,
  output logic               O_cmd_half,
  output logic [ROW_W-1:0]   O_cmd_row,
  output logic               O_cmd_last,
  output logic               O_busy,
  output logic               O_overrun
);

  state_e              state_q, state_d;
  row_desc_t           active_q, active_d;
  row_desc_t           pend_q, pend_d;
  logic                pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0]   counter_q, counter_d;
  logic                last_q, last_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;

  row_desc_t           new_desc_s;
  logic                capture_s;
  logic                xfer_s;

  // Incoming descriptor and handshake qualifiers.
  always_comb begin
    new_desc_s.half  = I_row_half;
    new_desc_s.row   = I_row_index;
    new_desc_s.count = clamp_count(I_batch_count);
    capture_s        = I_row_done && (I_batch_count != COUNT_W'(0));
    xfer_s           = valid_q && I_cmd_ready;
  end

  // Next-state logic for scheduler state, descriptors and batch counter.
  always_comb begin
    state_d    = state_q;
    active_d   = active_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    counter_d  = counter_q;
    overrun_d  = 1'b0;

    if (I_frame_start) begin
      // Flush wins; a coincident row is captured into the emptied scheduler.
      pend_d     = '0;
      pend_vld_d = 1'b0;
      counter_d  = '0;
      if (capture_s) begin
        active_d = new_desc_s;
        state_d  = ST_ISSUE;
      end else begin
        active_d = '0;
        state_d  = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (capture_s) begin
            active_d  = new_desc_s;
            counter_d = '0;
            state_d   = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (xfer_s && last_q) begin
            counter_d = '0;
            if (pend_vld_q) begin
              active_d = pend_q;
              if (capture_s) begin
                pend_d = new_desc_s;
              end else begin
                pend_vld_d = 1'b0;
              end
            end else if (capture_s) begin
              active_d = new_desc_s;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            if (xfer_s) begin
              counter_d = counter_q + ADDR_W'(1);
            end else begin
              counter_d = counter_q;
            end
            if (capture_s) begin
              if (pend_vld_q) begin
                overrun_d = 1'b1;
              end else begin
                pend_d     = new_desc_s;
                pend_vld_d = 1'b1;
              end
            end else begin
              pend_vld_d = pend_vld_q;
            end
          end
        end
        default: begin
          state_d    = ST_IDLE;
          active_d   = '0;
          pend_d     = '0;
          pend_vld_d = 1'b0;
          counter_d  = '0;
        end
      endcase
    end

    valid_d = (state_d == ST_ISSUE);
    busy_d  = (state_d == ST_ISSUE);
    last_d  = (state_d == ST_ISSUE) &&
              ({1'b0, counter_d} == (active_d.count - COUNT_W'(1)));
  end

  // State and output registers.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q    <= ST_IDLE;
      active_q   <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      counter_q  <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      counter_q  <= counter_d;
      last_q     <= last_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign O_cmd_valid = valid_q;
  assign O_cmd_addr  = counter_q;
  assign O_cmd_half  = active_q.half;
  assign O_cmd_row   = active_q.row;
  assign O_cmd_last  = last_q;
  assign O_busy      = busy_q;
  assign O_overrun   = overrun_q;

endmodule

// File: tb/tb_row_readout_scheduler.sv
// Directed table-driven bench for row_readout_scheduler plus hand sequences
// for the width clamp and asynchronous reset mid-row.
module tb_row_readout_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        row_done = 1'b0;
  logic        row_half = 1'b0;
  logic [10:0] row_index = 11'd0;
  logic [7:0]  batch_count = 8'd0;
  logic        cmd_ready = 1'b0;
  logic        cmd_valid;
  logic [6:0]  cmd_addr;
  logic        cmd_half;
  logic [10:0] cmd_row;
  logic        cmd_last;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  row_readout_scheduler dut (
    .I_clk(clk), .I_rst(rst), .I_frame_start(frame_start),
    .I_row_done(row_done), .I_row_half(row_half), .I_row_index(row_index),
    .I_batch_count(batch_count), .O_cmd_valid(cmd_valid), .I_cmd_ready(cmd_ready),
    .O_cmd_addr(cmd_addr), .O_cmd_half(cmd_half), .O_cmd_row(cmd_row),
    .O_cmd_last(cmd_last), .O_busy(busy), .O_overrun(overrun)
  );

  always #5 clk = ~clk;

  // Observed bundle: {valid, addr[6:0], half, row[10:0], last, busy, overrun}
  logic [22:0] obs;
  assign obs = {cmd_valid, cmd_addr, cmd_half, cmd_row, cmd_last, busy, overrun};

  typedef struct {
    logic        fs;
    logic        rd;
    logic        h;
    logic [10:0] r;
    logic [7:0]  c;
    logic        rdy;
    logic [22:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [22:0] pk(input logic v, input int a, input logic h,
                                     input int r, input logic l, input logic b,
                                     input logic o);
    logic [6:0]  a7;
    logic [10:0] r11;
    a7  = 7'(a);
    r11 = 11'(r);
    return {v, a7, h, r11, l, b, o};
  endfunction

  task automatic addv(input logic fs, input logic rd, input logic h, input int r,
                      input int c, input logic rdy, input logic ev, input int ea,
                      input logic eh, input int er, input logic el, input logic eb,
                      input logic eo);
    vec_t v;
    v.fs  = fs;
    v.rd  = rd;
    v.h   = h;
    v.r   = 11'(r);
    v.c   = 8'(c);
    v.rdy = rdy;
    v.exp = pk(ev, ea, eh, er, el, eb, eo);
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%0b a=%0d h=%0b r=%0d l=%0b b=%0b o=%0b, want v=%0b a=%0d h=%0b r=%0d l=%0b b=%0b o=%0b",
               name, act[22], act[21:15], act[14], act[13:3], act[2], act[1], act[0],
               exp[22], exp[21:15], exp[14], exp[13:3], exp[2], exp[1], exp[0]);
    end
  endtask

  initial begin
    //   fs rd h  row  cnt rdy | v addr h row last busy ovr
    addv(0, 1, 1,  5,  4, 1,   1, 0, 1,  5, 0, 1, 0);  // basic row, ready high
    addv(0, 0, 0,  0,  0, 1,   1, 1, 1,  5, 0, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   1, 2, 1,  5, 0, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   1, 3, 1,  5, 1, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   0, 0, 1,  5, 0, 0, 0);
    addv(0, 1, 0,  7,  3, 0,   1, 0, 0,  7, 0, 1, 0);  // stalls hold fields
    addv(0, 0, 0,  0,  0, 0,   1, 0, 0,  7, 0, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   1, 1, 0,  7, 0, 1, 0);
    addv(0, 0, 0,  0,  0, 0,   1, 1, 0,  7, 0, 1, 0);
    addv(0, 0, 0,  0,  0, 0,   1, 1, 0,  7, 0, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   1, 2, 0,  7, 1, 1, 0);
    addv(0, 0, 0,  0,  0, 0,   1, 2, 0,  7, 1, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   0, 0, 0,  7, 0, 0, 0);
    addv(0, 1, 0, 10,  3, 1,   1, 0, 0, 10, 0, 1, 0);  // A, then B pending, C dropped
    addv(0, 1, 1, 11,  2, 1,   1, 1, 0, 10, 0, 1, 0);
    addv(0, 1, 0, 12,  5, 1,   1, 2, 0, 10, 1, 1, 1);
    addv(0, 0, 0,  0,  0, 1,   1, 0, 1, 11, 0, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   1, 1, 1, 11, 1, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   0, 0, 1, 11, 0, 0, 0);
    addv(0, 1, 0, 20,  2, 1,   1, 0, 0, 20, 0, 1, 0);  // row_done on last xfer, pend empty
    addv(0, 0, 0,  0,  0, 1,   1, 1, 0, 20, 1, 1, 0);
    addv(0, 1, 1, 21,  1, 1,   1, 0, 1, 21, 1, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   0, 0, 1, 21, 0, 0, 0);
    addv(0, 1, 0, 30,  2, 1,   1, 0, 0, 30, 0, 1, 0);  // row_done on last xfer, pend full
    addv(0, 1, 1, 31,  1, 1,   1, 1, 0, 30, 1, 1, 0);
    addv(0, 1, 0, 32,  1, 1,   1, 0, 1, 31, 1, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   1, 0, 0, 32, 1, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   0, 0, 0, 32, 0, 0, 0);
    addv(0, 1, 1, 33,  0, 1,   0, 0, 0, 32, 0, 0, 0);  // zero-count row ignored
    addv(0, 1, 1, 40,  5, 1,   1, 0, 1, 40, 0, 1, 0);  // frame start flushes pending
    addv(0, 1, 0, 41,  2, 0,   1, 0, 1, 40, 0, 1, 0);
    addv(1, 0, 0,  0,  0, 0,   0, 0, 0,  0, 0, 0, 0);
    addv(0, 0, 0,  0,  0, 1,   0, 0, 0,  0, 0, 0, 0);
    addv(0, 0, 0,  0,  0, 1,   0, 0, 0,  0, 0, 0, 0);
    addv(0, 1, 1, 50,  2, 0,   1, 0, 1, 50, 0, 1, 0);  // frame start with row_done
    addv(1, 1, 0, 51,  3, 1,   1, 0, 0, 51, 0, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   1, 1, 0, 51, 0, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   1, 2, 0, 51, 1, 1, 0);
    addv(0, 0, 0,  0,  0, 1,   0, 0, 0, 51, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset", obs, 23'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      frame_start = vq[i].fs;
      row_done    = vq[i].rd;
      row_half    = vq[i].h;
      row_index   = vq[i].r;
      batch_count = vq[i].c;
      cmd_ready   = vq[i].rdy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), obs, vq[i].exp);
    end

    // Oversized row is clamped to 120 batches.
    @(negedge clk);
    frame_start = 1'b0;
    row_done    = 1'b1;
    row_half    = 1'b0;
    row_index   = 11'd60;
    batch_count = 8'd200;
    cmd_ready   = 1'b1;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      row_done = 1'b0;
      check($sformatf("clamp%0d", i), obs, pk(1'b1, i, 1'b0, 60, (i == 119), 1'b1, 1'b0));
    end
    @(posedge clk);
    #1;
    check("clamp_end", obs, pk(1'b0, 0, 1'b0, 60, 1'b0, 1'b0, 1'b0));

    // Asynchronous reset mid-row, nothing resumes afterwards.
    @(negedge clk);
    row_done    = 1'b1;
    row_half    = 1'b1;
    row_index   = 11'd70;
    batch_count = 8'd10;
    @(posedge clk);
    #1;
    row_done = 1'b0;
    check("pre_rst", obs, pk(1'b1, 0, 1'b1, 70, 1'b0, 1'b1, 1'b0));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst", obs, 23'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst", obs, 23'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
